// File: rtl/multdiv_sched.sv
// multdiv_sched: sequencing controller for the shared iterative multiplier/divider.
// Accepts one op, pulses the unit, waits for md_ready (with timeout), and holds
// the result for writeback until acknowledged. Drives busy/hazard for decode.
// Optional build macro MULTDIV_BYPASS_EN: trivial ops (mult by zero, div by zero)
// skip the unit and complete straight from START.
module multdiv_sched #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 34,
  parameter int SLACK       = 4,
  parameter int CNT_W       = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        req_ready,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_ready,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exc,
  input  logic        wb_ack,
  input  logic [4:0]  src1,
  input  logic [4:0]  src2,
  output logic        busy,
  output logic        hazard,
  output logic        err_timeout
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  // Last counter value before timeout: counter reads k-1 in the k-th BUSY cycle.
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES + SLACK - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES + SLACK - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data_q, data_d;
  logic              exc_q, exc_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  last_cnt;
  logic              bypass;

  assign last_cnt = op_q ? DIV_LAST : MULT_LAST;

`ifdef MULTDIV_BYPASS_EN
  assign bypass = op_q ? (b_q == 32'd0) : ((a_q == 32'd0) || (b_q == 32'd0));
`else
  assign bypass = 1'b0;
`endif

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign md_ctrl_mult = (state_q == START) & ~op_q & ~bypass;
  assign md_ctrl_div  = (state_q == START) &  op_q & ~bypass;
  assign md_opA       = a_q;
  assign md_opB       = b_q;
  assign wb_valid     = (state_q == DONE);
  assign wb_rd        = rd_q;
  assign wb_data      = data_q;
  assign wb_exc       = exc_q;
  assign err_timeout  = err_q;
  assign hazard       = busy & (rd_q != 5'd0) & ((src1 == rd_q) | (src2 == rd_q));

  // State register and latched operands/results; async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      exc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept, pulse, count/timeout, hold until ack.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    data_d  = data_q;
    exc_d   = exc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          rd_d    = req_rd;
          state_d = START;
        end
      end
      START: begin
        cnt_d = '0;
        if (bypass) begin
          data_d  = 32'd0;
          exc_d   = op_q;
          state_d = DONE;
        end else begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        // md_ready takes priority over a coincident timeout.
        if (md_ready) begin
          data_d  = md_result;
          exc_d   = md_exception;
          state_d = DONE;
        end else if (cnt_q == last_cnt) begin
          data_d  = 32'd0;
          exc_d   = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (wb_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multdiv_sched.sv
// Scoreboard bench for multdiv_sched: stimulus pushes expected writebacks
// (rd, data, exc, arrival cycle); a negedge monitor pops and compares.
module tb_multdiv_sched;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_op = 1'b0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [4:0]  req_rd = '0;
  logic        req_ready, md_ctrl_mult, md_ctrl_div;
  logic [31:0] md_opA, md_opB;
  logic [31:0] md_result = '0;
  logic        md_exception = 1'b0, md_ready = 1'b0;
  logic        wb_valid, wb_exc, busy, hazard, err_timeout;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_ack = 1'b0;
  logic [4:0]  src1 = '0, src2 = '0;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        exc;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  multdiv_sched dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_rd(req_rd), .req_ready(req_ready),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_opA(md_opA), .md_opB(md_opB),
    .md_result(md_result), .md_exception(md_exception), .md_ready(md_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_exc(wb_exc),
    .wb_ack(wb_ack), .src1(src1), .src2(src2),
    .busy(busy), .hazard(hazard), .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: counts cycles and pulses, scores each new writeback.
  always @(negedge clock) begin
    ncyc++;
    if (md_ctrl_mult || md_ctrl_div) pulses++;
    if (wb_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", {31'd0, wb_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("wb  cyc=%0d rd=%0d data=%0h exc=%0b", ncyc, wb_rd, wb_data, wb_exc);
        chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
        chk("wb_data", wb_data, e.data);
        chk("wb_exc", {31'd0, wb_exc}, {31'd0, e.exc});
        chk("wb_latency", ncyc, e.cyc);
      end
    end
    prev_valid = wb_valid;
  end

  // One op: n = BUSY cycle of md_ready (<0 = never), ack_dly = DONE hold cycles.
  task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int n, input logic [31:0] res,
                        input logic mexc, input int ack_dly, input bit hz);
    bit   bp;
    int   nb, acc, p0;
    exp_t e;
    bp = 0;
`ifdef MULTDIV_BYPASS_EN
    bp = op ? (b == 0) : (a == 0 || b == 0);
`endif
    for (int i = 0; i < 50 && !req_ready; i++) begin @(posedge clock); #1; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1; req_op = op; req_a = a; req_b = b; req_rd = rd;
    @(posedge clock); #1;
    req_valid = 0;
    acc = ncyc;
    p0  = pulses;
    if (bp)         begin nb = 0; e.data = 0;   e.exc = op;   end
    else if (n < 0) begin nb = op ? 38 : 37; e.data = 0; e.exc = 1; end
    else            begin nb = n; e.data = res; e.exc = mexc; end
    e.rd = rd; e.cyc = acc + 2 + nb;
    sb.push_back(e);
    $display("req op=%0b a=%0h b=%0h rd=%0d expect_cyc=%0d", op, a, b, rd, e.cyc);
    // START cycle
    chk("start_mult", {31'd0, md_ctrl_mult}, {31'd0, ~op & ~bp});
    chk("start_div", {31'd0, md_ctrl_div}, {31'd0, op & ~bp});
    chk("start_opA", md_opA, a);
    chk("start_opB", md_opB, b);
    chk("start_ready", {31'd0, req_ready}, 32'd0);
    if (hz) begin
      src1 = rd; src2 = rd; #1;
      chk("hazard_match", {31'd0, hazard}, {31'd0, rd != 0});
      src1 = rd + 5'd1; src2 = rd + 5'd2; #1;
      chk("hazard_nomatch", {31'd0, hazard}, 32'd0);
      src1 = rd; src2 = rd;
    end
    if (!bp && n >= 0) begin
      for (int i = 0; i < n; i++) begin @(posedge clock); #1; end
      md_ready = 1; md_result = res; md_exception = mexc;
      @(posedge clock); #1;
      md_ready = 0; md_result = 32'hdead_beef; md_exception = 0;
    end
    for (int i = 0; i < 100 && !wb_valid; i++) begin @(posedge clock); #1; end
    chk("wb_valid_seen", {31'd0, wb_valid}, 32'd1);
    if (hz) chk("hazard_done", {31'd0, hazard}, {31'd0, rd != 0});
    for (int i = 0; i < ack_dly; i++) begin
      req_valid = 1; req_op = ~op; req_rd = rd + 5'd1;
      chk("hold_valid", {31'd0, wb_valid}, 32'd1);
      chk("hold_data", wb_data, e.data);
      chk("hold_rd", {27'd0, wb_rd}, {27'd0, rd});
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clock); #1;
    end
    req_valid = 0;
    wb_ack = 1;
    @(posedge clock); #1;
    wb_ack = 0;
    chk("post_ack_ready", {31'd0, req_ready}, 32'd1);
    chk("post_ack_hazard", {31'd0, hazard}, 32'd0);
    chk("op_pulses", pulses - p0, bp ? 0 : 1);
    src1 = 0; src2 = 0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    chk("rst_opA", md_opA, 32'd0);
    reset = 1;
    @(posedge clock); #1;

    // Mult 7*6 -> 42 after 33 cycles
    run_op(1'b0, 32'd7, 32'd6, 5'd5, 33, 32'd42, 1'b0, 0, 0);
    // md_ready coincides with timeout compare: normal completion
    run_op(1'b0, 32'd3, 32'd4, 5'd6, 37, 32'd12, 1'b0, 0, 0);
    chk("tie_no_err", {31'd0, err_timeout}, 32'd0);
    // Div timeout
    run_op(1'b1, 32'd100, 32'd7, 5'd3, -1, 32'd0, 1'b0, 0, 0);
    chk("err_set", {31'd0, err_timeout}, 32'd1);
    // Hazard with rd=9, long ack hold with req_valid pressed
    run_op(1'b0, 32'h1234, 32'h10, 5'd9, 5, 32'h12340, 1'b0, 10, 1);
    // rd=0 op: no hazard
    run_op(1'b1, 32'd20, 32'd4, 5'd0, 3, 32'd5, 1'b0, 0, 1);
    chk("err_sticky", {31'd0, err_timeout}, 32'd1);
    // Trivial ops (bypassed when the feature is built in)
    run_op(1'b0, 32'd0, 32'd5, 5'd2, 33, 32'd0, 1'b0, 0, 0);
    run_op(1'b1, 32'd8, 32'd0, 5'd7, 34, 32'hffff_ffff, 1'b1, 0, 0);

    // Reset during BUSY at counter=12
    req_valid = 1; req_op = 0; req_a = 32'd9; req_b = 32'd9; req_rd = 5'd4;
    @(posedge clock); #1;
    req_valid = 0;
    repeat (13) begin @(posedge clock); #1; end
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 0; #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, err_timeout}, 32'd0);
    chk("arst_opA", md_opA, 32'd0);
    repeat (2) @(posedge clock);
    #1; reset = 1;
    md_ready = 1; md_result = 32'd81;
    @(posedge clock); #1;
    md_ready = 0;
    repeat (5) begin @(posedge clock); #1; end
    chk("stray_ready_wb", {31'd0, wb_valid}, 32'd0);
    chk("stray_ready_idle", {31'd0, req_ready}, 32'd1);
    chk("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_sched.md
Name: multdiv_sched

Overview:
- Sequencing controller for the shared iterative multiplier/divider.
- Accepts one mult/div op from execute via a valid/ready handshake and latches operands and destination tag.
- Issues a one-cycle start pulse to the unit and counts cycles until the unit reports ready, then holds the result for writeback until acknowledged.
- Drives busy/hazard outputs so the pipeline stalls dependent instructions.

Parameters:
- MULT_CYCLES, 33, expected cycles from start pulse to md_ready for multiply
- DIV_CYCLES, 34, expected cycles from start pulse to md_ready for divide
- SLACK, 4, extra cycles tolerated beyond expected count before timeout
- CNT_W, 6, cycle-counter width; must hold DIV_CYCLES+SLACK

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  execute stage presents a mult/div op
- req_op  in  1  0 = multiply, 1 = divide
- req_a  in  32  operand A
- req_b  in  32  operand B
- req_rd  in  5  destination register
- req_ready  out  1  scheduler can accept an op
- md_ctrl_mult  out  1  one-cycle multiply start pulse
- md_ctrl_div  out  1  one-cycle divide start pulse
- md_opA  out  32  latched operand A, stable from START through DONE
- md_opB  out  32  latched operand B, stable from START through DONE
- md_result  in  32  unit result
- md_exception  in  1  unit exception (divide by zero / overflow)
- md_ready  in  1  unit result valid
- wb_valid  out  1  result available to writeback
- wb_rd  out  5  destination of held result
- wb_data  out  32  held result
- wb_exc  out  1  held exception flag
- wb_ack  in  1  writeback consumed result
- src1  in  5  decode source register 1
- src2  in  5  decode source register 2
- busy  out  1  state != IDLE
- hazard  out  1  decode must stall
- err_timeout  out  1  sticky: a timeout occurred since reset

Behaviour:
- Reset (reset low, async): state IDLE, counter 0. All outputs 0 except req_ready = 1. Latched op/rd/operands cleared. err_timeout cleared.
- Reset mid-operation aborts immediately: no start pulse, no wb_valid.
- FSM: IDLE -> START -> BUSY -> DONE -> IDLE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready: latch req_op, req_a, req_b, req_rd; next state START.
- START (1 cycle):
  - md_ctrl_mult = ~op, md_ctrl_div = op.
  - Counter <= 0; next state BUSY.
- BUSY:
  - Counter increments each cycle, saturating at all-ones.
  - md_ready high: latch md_result and md_exception; next state DONE.
  - Else if counter == LIMIT-1, where LIMIT = (op ? DIV_CYCLES : MULT_CYCLES) + SLACK: wb_data <= 0, wb_exc <= 1, err_timeout <= 1; next state DONE.
  - md_ready in the same cycle as the timeout compare wins: normal completion, no error.
- md_ready outside BUSY is ignored.
- DONE:
  - wb_valid = 1; wb_rd, wb_data, wb_exc held stable.
  - wb_ack high: next state IDLE.
  - wb_ack outside DONE is ignored.
- req_ready is 0 in START, BUSY and DONE. There is no same-cycle back-to-back accept. Minimum gap between accepts: 3 cycles plus unit latency plus ack wait.
- Accept-to-wb_valid latency = 2 + N cycles, where N is BUSY cycles up to and including the md_ready cycle.
- Only one op is in flight at a time.
- rd = 0 ops execute normally; wb_rd = 0 is passed through and writeback discards it.
- hazard = busy & (latched rd != 0) & (src1 == rd | src2 == rd). Combinational; includes DONE until ack.

Optional Feature:
- Macro: MULTDIV_BYPASS_EN
- Defined: in START, the unit is skipped for trivial ops and the FSM goes to DONE next cycle with no ctrl pulse:
  - multiply with either operand zero: wb_data = 0, wb_exc = 0.
  - divide with opB zero: wb_data = 0, wb_exc = 1.
  - err_timeout is unaffected.
- Not defined: every op pulses the unit and follows START -> BUSY.

Test Plan:
- Mult 7*6, rd=5; unit returns 42 with md_ready 33 cycles after pulse -> single md_ctrl_mult pulse; wb_valid at accept+35; wb_data=42, wb_rd=5, wb_exc=0; req_ready=1 the cycle after wb_ack.
- Div 100/7, rd=3; md_ready never asserted -> wb_valid after 38 BUSY cycles; wb_data=0, wb_exc=1; err_timeout=1 and still 1 after a later clean op.
- Busy with rd=9: src1=9 -> hazard=1; src2=9 with rd=0 op -> hazard=0; hazard stays 1 through DONE until ack.
- Hold wb_ack low 10 cycles in DONE -> wb_valid, wb_data and wb_rd stable; req_valid during this window is not accepted (req_ready=0).
- Assert reset low during BUSY at counter=12 -> outputs reset asynchronously; a later md_ready produces no wb_valid; after reset release, req_ready=1.
- With MULTDIV_BYPASS_EN: mult 0*5 -> no ctrl pulse, wb_valid at accept+2, wb_data=0; div 8/0 -> wb_exc=1. Without the macro, the same ops pulse the unit.
